fetch_stage_regs: RTL
=====================

// Module: fetch_stage_regs
// PURPOSE
//   Consumer end of the load-use stall protocol. Holds the PC register and the IF/ID pipeline register
//   and applies the stall/bubble requests (pc_write, if_id_write, ctrl_sel) issued by hazard detection.
//   Also handles branch-taken redirect/flush, gates the ID/EX control bundle, counts stall and flush
//   events, and runs a stall-duration watchdog. Sits between instruction memory and the decode stage.
// PARAMETERS
//   PC_WIDTH    64            PC and branch-target width
//   INST_WIDTH  32            instruction width
//   RESET_PC    0             PC value loaded at reset
//   CTRL_WIDTH  8             width of decode control bundle passed to ID/EX
//   CNT_WIDTH   16            width of the stall and flush event counters (saturating)
//   MAX_STALL   15            consecutive-stall limit before stall_timeout
// PORTS
//   clk            in   1           clock, rising edge
//   reset_n        in   1           synchronous reset, active-low
//   pc_write       in   1           1 = PC advances; 0 = hold PC (stall)
//   if_id_write    in   1           1 = IF/ID loads; 0 = hold IF/ID
//   ctrl_sel       in   1           1 = pass decode controls; 0 = insert bubble
//   branch_taken   in   1           redirect request from EX
//   branch_target  in   PC_WIDTH    redirect address
//   imem_inst      in   INST_WIDTH  instruction at pc_out (combinational imem)
//   id_ctrl_in     in   CTRL_WIDTH  control bundle from main decoder
//   pc_out         out  PC_WIDTH    current fetch PC
//   if_id_pc       out  PC_WIDTH    PC of instruction held in IF/ID
//   if_id_inst     out  INST_WIDTH  instruction held in IF/ID
//   if_id_valid    out  1           IF/ID holds a real instruction
//   id_ctrl_out    out  CTRL_WIDTH  gated control bundle to ID/EX
//   stalled        out  1           FSM in STALL
//   stall_timeout  out  1           sticky: stall exceeded MAX_STALL cycles
//   protocol_err   out  1           sticky: pc_write=1 while if_id_write=0
//   stall_count    out  CNT_WIDTH   cycles with pc_write=0 and no redirect
//   flush_count    out  CNT_WIDTH   branch redirects taken
// BEHAVIOUR
//   Reset (reset_n=0 at clk edge):
//   - pc_out=RESET_PC; if_id_pc=0; if_id_inst=NOP (32'h0000_0013); if_id_valid=0; FSM=RUN.
//   - All counters and sticky flags cleared. Reset mid-stall or mid-flush discards all state.
//   Priority per cycle: reset > branch_taken > stall > advance.
//   - branch_taken=1: pc_out<=branch_target; IF/ID<=NOP, valid=0; flush_count++.
//     These updates ignore pc_write and if_id_write. FSM->RUN, stall run-length cleared.
//   - Otherwise: pc_write=1 -> pc_out<=pc_out+4 (wraps mod 2^PC_WIDTH); 0 -> hold.
//   - if_id_write=1 -> IF/ID<={pc_out, imem_inst}, valid=1; 0 -> hold all IF/ID fields.
//   - Latency: fetched instruction visible on if_id_* one cycle after its PC is on pc_out.
//   id_ctrl_out (combinational) = (ctrl_sel & if_id_valid) ? id_ctrl_in : 0.
//   FSM states and transitions:
//   - RUN->STALL when pc_write=0 & ~branch_taken.
//   - STALL->RUN when pc_write=1 or branch_taken.
//   - STALL->STALL otherwise; stalled=1 iff in STALL (registered).
//   Watchdog: run-length counter counts consecutive STALL cycles, cleared on RUN entry.
//   - stall_timeout set the cycle the run-length reaches MAX_STALL+1; held until reset.
//   stall_count / flush_count saturate at all-ones, never wrap.
//   protocol_err set on any non-redirect cycle with pc_write=1 & if_id_write=0; held until reset.
//   - The combination is still applied as commanded (PC advances, IF/ID holds).
//   The pc_write=0 & if_id_write=1 combination is legal: IF/ID reloads the same PC.
// STRUCTURE
//   Shared package fetch_pkg: NOP_INST constant, fetch_state_t {RUN, STALL}, PC_STEP=4.
//   One sub-module: sat_counter (param WIDTH; inc, clr, count). Instantiated for stall_count,
//   flush_count and the watchdog run-length counter. Everything else inline.
// TESTING
//   1 Reset: hold reset_n=0 2 cycles -> pc_out=0, if_id_inst=0000_0013, valid=0, counters 0.
//   2 Free run 4 cycles, all enables 1, imem_inst=PC-derived -> pc_out 0,4,8,C, if_id_pc lags by 1.
//   3 Load-use stall: pc_write=if_id_write=ctrl_sel=0 for 1 cycle at pc=8 ->
//     pc and IF/ID hold, id_ctrl_out=0, stalled=1, stall_count=1.
//   4 branch_taken with target 0x100 during a stall -> next pc_out=0x100, valid=0,
//     flush_count=1, stalled=0.
//   5 pc_write=0 held 16 cycles (MAX_STALL=15) -> stall_timeout rises on cycle 16,
//     persists after pc_write=1.
//   6 pc_write=1, if_id_write=0 -> protocol_err=1; reset mid-stall clears it and returns pc_out to 0.

Source files
------------

// File: rtl/fetch_stage_regs_pkg.sv
// Shared fetch-stage definitions: bubble instruction, FSM state type and PC increment.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int unsigned PC_STEP  = 4;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_regs_if.sv
// Hazard-control, redirect and IF/ID bus between the pipeline control and the fetch stage.
interface fetch_stage_regs_if #(
  parameter int unsigned PC_WIDTH   = 64,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  pc_write;
  logic                  if_id_write;
  logic                  ctrl_sel;
  logic                  branch_taken;
  logic [PC_WIDTH-1:0]   branch_target;
  logic [INST_WIDTH-1:0] imem_inst;
  logic [CTRL_WIDTH-1:0] id_ctrl_in;

  logic [PC_WIDTH-1:0]   pc_out;
  logic [PC_WIDTH-1:0]   if_id_pc;
  logic [INST_WIDTH-1:0] if_id_inst;
  logic                  if_id_valid;
  logic [CTRL_WIDTH-1:0] id_ctrl_out;
  logic                  stalled;
  logic                  stall_timeout;
  logic                  protocol_err;
  logic [CNT_WIDTH-1:0]  stall_count;
  logic [CNT_WIDTH-1:0]  flush_count;

  modport master (
    output pc_write, if_id_write, ctrl_sel, branch_taken, branch_target,
           imem_inst, id_ctrl_in,
    input  pc_out, if_id_pc, if_id_inst, if_id_valid, id_ctrl_out,
           stalled, stall_timeout, protocol_err, stall_count, flush_count
  );

  modport slave (
    input  pc_write, if_id_write, ctrl_sel, branch_taken, branch_target,
           imem_inst, id_ctrl_in,
    output pc_out, if_id_pc, if_id_inst, if_id_valid, id_ctrl_out,
           stalled, stall_timeout, protocol_err, stall_count, flush_count
  );
endinterface

// File: rtl/fetch_stage_regs_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_stage_regs.sv
// PC and IF/ID registers applying stall/bubble/redirect requests, with event counters and stall watchdog.
module fetch_stage_regs
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH   = 64,
  parameter int unsigned         INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned         CTRL_WIDTH = 8,
  parameter int unsigned         CNT_WIDTH  = 16,
  parameter int unsigned         MAX_STALL  = 15
) (
  input logic               clk,
  input logic               reset_n,
  fetch_stage_regs_if.slave bus
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL + 2);

  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   if_id_pc_q;
  logic [INST_WIDTH-1:0] if_id_inst_q;
  logic                  if_id_valid_q;
  logic                  timeout_q;
  logic                  perr_q;
  fetch_state_t          state_q;
  logic [RUN_W-1:0]      run_len;
  logic                  stall_cycle;
  logic                  redirect;

  assign redirect    = bus.branch_taken;
  assign stall_cycle = ~bus.pc_write & ~redirect;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= INST_WIDTH'(NOP_INST);
      if_id_valid_q <= 1'b0;
    end else if (redirect) begin
      pc_q          <= bus.branch_target;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= INST_WIDTH'(NOP_INST);
      if_id_valid_q <= 1'b0;
    end else begin
      if (bus.pc_write) begin
        pc_q <= pc_q + PC_WIDTH'(PC_STEP);
      end
      if (bus.if_id_write) begin
        if_id_pc_q    <= pc_q;
        if_id_inst_q  <= bus.imem_inst;
        if_id_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     state_q <= stall_cycle ? STALL : RUN;
        STALL:   state_q <= (bus.pc_write || redirect) ? RUN : STALL;
        default: state_q <= RUN;
      endcase
    end
  end

  // run_len already holds MAX_STALL on the cycle that makes it MAX_STALL+1
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (stall_cycle && (run_len == RUN_W'(MAX_STALL))) begin
        timeout_q <= 1'b1;
      end
      if (!redirect && bus.pc_write && !bus.if_id_write) begin
        perr_q <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (stall_cycle),
    .count   (bus.stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .inc     (redirect),
    .count   (bus.flush_count)
  );

  sat_counter #(.WIDTH(RUN_W)) u_run_len (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (~stall_cycle),
    .inc     (stall_cycle),
    .count   (run_len)
  );

  assign bus.pc_out        = pc_q;
  assign bus.if_id_pc      = if_id_pc_q;
  assign bus.if_id_inst    = if_id_inst_q;
  assign bus.if_id_valid   = if_id_valid_q;
  assign bus.stalled       = (state_q == STALL);
  assign bus.stall_timeout = timeout_q;
  assign bus.protocol_err  = perr_q;
  assign bus.id_ctrl_out   = (bus.ctrl_sel && if_id_valid_q) ? bus.id_ctrl_in : '0;

endmodule
